// File: rtl/grayscale_downsampler_pkg.sv
// Shared sizing helpers for the grayscale box-filter downsampler.
// Latency: none (compile-time functions only).
// Backpressure: not applicable.
package grayscale_downsampler_pkg;

  // Ceiling log2: number of bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Width of a counter that runs 0..count-1, never narrower than one bit.
  function automatic int cnt_width(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

  // Number of bins needed to cover 'extent' pixels, last bin possibly partial.
  function automatic int ceil_div(input int extent, input int step);
    return (extent + step - 1) / step;
  endfunction

  // Accumulator width that holds a full bin of maximum-value pixels.
  function automatic int calc_acc_width(input int data_width, input int bin_size);
    return data_width + clog2(bin_size);
  endfunction

endpackage

// File: rtl/downsampler_accum_mem.sv
// Per-bin-column running-sum store: one synchronous write port, one combinational read port.
// Latency: write lands on the next rising edge; read data follows rd_addr in the same cycle.
// Backpressure: none; a write is accepted on every cycle wr_en is high.
module downsampler_accum_mem
  import grayscale_downsampler_pkg::*;
#(
  parameter int depth  = 80,
  parameter int width  = 13,
  parameter int addr_w = cnt_width(depth)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [addr_w-1:0] wr_addr,
  input  logic [width-1:0]  wr_dat,
  input  logic [addr_w-1:0] rd_addr,
  output logic [width-1:0]  rd_dat
);

  logic [width-1:0] mem [depth];

  // Store the updated column sum; reset clears every column so no stale sum survives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Combinational read, so a write from the previous cycle is already visible.
  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/grayscale_downsampler.sv
// Streaming bin_width x bin_height box-filter downsampler for raster 8-bit grayscale video.
// Latency: data_out_valid pulses 2 clocks after the edge that samples a bin's final pixel.
// Backpressure: none; accepts one pixel per clock with any gap pattern on data_in_valid.
// Build option GRAYSCALE_DOWNSAMPLER_ROUND_EN: round-to-nearest average, saturated; default truncates.
module grayscale_downsampler
  import grayscale_downsampler_pkg::*;
#(
  parameter int data_width   = 8,
  parameter int bin_width    = 4,
  parameter int bin_height   = 8,
  parameter int image_width  = 320,
  parameter int image_height = 240
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_in_valid,
  input  logic [data_width-1:0] data_in,
  output logic                  data_out_valid,
  output logic [data_width-1:0] data_out
);

  localparam int num_bins_x = ceil_div(image_width, bin_width);
  localparam int num_bins_y = ceil_div(image_height, bin_height);
  localparam int bin_size   = bin_width * bin_height;
  localparam int acc_width  = calc_acc_width(data_width, bin_size);

  localparam int ix_w = cnt_width(bin_width);
  localparam int bx_w = cnt_width(num_bins_x);
  localparam int iy_w = cnt_width(bin_height);
  localparam int by_w = cnt_width(num_bins_y);

  // Width/height of the rightmost bin column and bottom bin row (may be partial).
  localparam int last_bin_w = image_width - (num_bins_x - 1) * bin_width;
  localparam int last_bin_h = image_height - (num_bins_y - 1) * bin_height;

  localparam logic [ix_w-1:0] ix_max  = ix_w'(bin_width - 1);
  localparam logic [ix_w-1:0] ix_edge = ix_w'(last_bin_w - 1);
  localparam logic [bx_w-1:0] bx_max  = bx_w'(num_bins_x - 1);
  localparam logic [iy_w-1:0] iy_max  = iy_w'(bin_height - 1);
  localparam logic [iy_w-1:0] iy_edge = iy_w'(last_bin_h - 1);
  localparam logic [by_w-1:0] by_max  = by_w'(num_bins_y - 1);

  // Raster position, split into bin index and offset within the bin.
  logic [ix_w-1:0] intra_bin_xidx;
  logic [bx_w-1:0] inter_bin_xidx;
  logic [iy_w-1:0] intra_bin_yidx;
  logic [by_w-1:0] inter_bin_yidx;

  logic row_end;
  logic frame_end;
  logic x_final;
  logic y_final;
  logic first_px;

  // Pipeline tracking: index 0 = accumulate stage, index 1 = divide stage.
  logic [1:0] data_valid;
  logic [1:0] x_at_final_pixel_in_bin;
  logic [1:0] y_at_final_pixel_in_bin;

  logic [data_width-1:0] pix_s0;
  logic [bx_w-1:0]       col_s0;
  logic                  first_s0;
  logic [acc_width-1:0]  rd_dat;
  logic [acc_width-1:0]  sum_s0;
  logic [acc_width-1:0]  sum_s1;
  logic [data_width-1:0] avg_dat;
  logic                  out_fire;

  // Decode where the current input pixel sits relative to its bin and the frame edges.
  always_comb begin
    row_end   = (inter_bin_xidx == bx_max) && (intra_bin_xidx == ix_edge);
    frame_end = (inter_bin_yidx == by_max) && (intra_bin_yidx == iy_edge);
    x_final   = (intra_bin_xidx == ix_max) || row_end;
    y_final   = (intra_bin_yidx == iy_max) || frame_end;
    first_px  = (intra_bin_xidx == '0) && (intra_bin_yidx == '0);
  end

  // Advance the raster position on each accepted pixel; wrap at bin, row and frame ends.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      intra_bin_xidx <= '0;
      inter_bin_xidx <= '0;
      intra_bin_yidx <= '0;
      inter_bin_yidx <= '0;
    end else if (data_in_valid) begin
      if (x_final) begin
        intra_bin_xidx <= '0;
        inter_bin_xidx <= row_end ? '0 : inter_bin_xidx + 1'b1;
      end else begin
        intra_bin_xidx <= intra_bin_xidx + 1'b1;
      end
      if (row_end) begin
        if (y_final) begin
          intra_bin_yidx <= '0;
          inter_bin_yidx <= frame_end ? '0 : inter_bin_yidx + 1'b1;
        end else begin
          intra_bin_yidx <= intra_bin_yidx + 1'b1;
        end
      end
    end
  end

  // Stage 0 capture: the pixel and its bin bookkeeping travel together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_valid[0]              <= 1'b0;
      x_at_final_pixel_in_bin[0] <= 1'b0;
      y_at_final_pixel_in_bin[0] <= 1'b0;
      pix_s0                     <= '0;
      col_s0                     <= '0;
      first_s0                   <= 1'b0;
    end else begin
      data_valid[0] <= data_in_valid;
      if (data_in_valid) begin
        x_at_final_pixel_in_bin[0] <= x_final;
        y_at_final_pixel_in_bin[0] <= y_final;
        pix_s0                     <= data_in;
        col_s0                     <= inter_bin_xidx;
        first_s0                   <= first_px;
      end
    end
  end

  // Read-modify-write completes inside stage 0, so a back-to-back pixel on the
  // same column reads the sum written one edge earlier straight from the store.
  always_comb begin
    sum_s0 = first_s0 ? acc_width'(pix_s0) : rd_dat + acc_width'(pix_s0);
  end

  downsampler_accum_mem #(
    .depth (num_bins_x),
    .width (acc_width),
    .addr_w(bx_w)
  ) u_accum_mem (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (data_valid[0]),
    .wr_addr(col_s0),
    .wr_dat (sum_s0),
    .rd_addr(col_s0),
    .rd_dat (rd_dat)
  );

  // Stage 1 capture: updated sum plus the bin-completion flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_valid[1]              <= 1'b0;
      x_at_final_pixel_in_bin[1] <= 1'b0;
      y_at_final_pixel_in_bin[1] <= 1'b0;
      sum_s1                     <= '0;
    end else begin
      data_valid[1] <= data_valid[0];
      if (data_valid[0]) begin
        x_at_final_pixel_in_bin[1] <= x_at_final_pixel_in_bin[0];
        y_at_final_pixel_in_bin[1] <= y_at_final_pixel_in_bin[0];
        sum_s1                     <= sum_s0;
      end
    end
  end

`ifdef GRAYSCALE_DOWNSAMPLER_ROUND_EN
  logic [acc_width:0] rnd_quot;

  // Round to nearest by biasing with half a bin; one extra bit keeps the bias from wrapping.
  always_comb begin
    rnd_quot = ({1'b0, sum_s1} + (acc_width + 1)'(bin_size / 2)) / (acc_width + 1)'(bin_size);
    avg_dat  = (rnd_quot > (acc_width + 1)'((1 << data_width) - 1)) ? '1 : data_width'(rnd_quot);
  end
`else
  // Truncating average; partial edge bins still divide by the full bin size.
  always_comb begin
    avg_dat = data_width'(sum_s1 / acc_width'(bin_size));
  end
`endif

  assign out_fire = data_valid[1] & x_at_final_pixel_in_bin[1] & y_at_final_pixel_in_bin[1];

  // Output register: strobe once per completed bin, hold the last average between strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out_valid <= 1'b0;
      data_out       <= '0;
    end else begin
      data_out_valid <= out_fire;
      if (out_fire) begin
        data_out <= avg_dat;
      end
    end
  end

endmodule

// File: tb/tb_grayscale_downsampler.sv
// Bench for grayscale_downsampler: two instances (4x8 bins with partial edges, 6x12 full bins).
// Latency: expects each bin average exactly 2 clocks after its final pixel is sampled.
// Backpressure: none; stimulus uses continuous and 1/3-duty valid patterns.
module tb_grayscale_downsampler;

  localparam int A_BW = 4;
  localparam int A_BH = 8;
  localparam int A_W  = 22;
  localparam int A_H  = 20;
  localparam int B_BW = 6;
  localparam int B_BH = 12;
  localparam int B_W  = 24;
  localparam int B_H  = 24;

  typedef struct {
    int     val;
    longint cyc;
  } exp_t;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       a_in_vld = 1'b0;
  logic [7:0] a_in_dat = 8'h00;
  logic       a_out_vld;
  logic [7:0] a_out_dat;
  logic       b_in_vld = 1'b0;
  logic [7:0] b_in_dat = 8'h00;
  logic       b_out_vld;
  logic [7:0] b_out_dat;

  int     vectors     = 0;
  int     miscompares = 0;
  longint cyc         = 0;

  exp_t       exp_a[$];
  exp_t       exp_b[$];
  logic [7:0] img [2][32][32];
  int         px_x [2];
  int         px_y [2];
  int         out_cnt [2];
  int         first_dat [2];

  always #5 clock = ~clock;

  grayscale_downsampler #(
    .data_width(8), .bin_width(A_BW), .bin_height(A_BH), .image_width(A_W), .image_height(A_H)
  ) dut_a (
    .clock(clock), .reset(reset),
    .data_in_valid(a_in_vld), .data_in(a_in_dat),
    .data_out_valid(a_out_vld), .data_out(a_out_dat)
  );

  grayscale_downsampler #(
    .data_width(8), .bin_width(B_BW), .bin_height(B_BH), .image_width(B_W), .image_height(B_H)
  ) dut_b (
    .clock(clock), .reset(reset),
    .data_in_valid(b_in_vld), .data_in(b_in_dat),
    .data_out_valid(b_out_vld), .data_out(b_out_dat)
  );

  task automatic check_eq(input string tag, input longint got, input longint expv);
    vectors++;
    if (got != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic int geo_bw(input int sel); return (sel == 0) ? A_BW : B_BW; endfunction
  function automatic int geo_bh(input int sel); return (sel == 0) ? A_BH : B_BH; endfunction
  function automatic int geo_w(input int sel);  return (sel == 0) ? A_W  : B_W;  endfunction
  function automatic int geo_h(input int sel);  return (sel == 0) ? A_H  : B_H;  endfunction
  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction

  function automatic int bins_per_frame(input int sel);
    return ((geo_w(sel) + geo_bw(sel) - 1) / geo_bw(sel)) *
           ((geo_h(sel) + geo_bh(sel) - 1) / geo_bh(sel));
  endfunction

  // Reference average of bin (bx,by) straight from the stored frame.
  function automatic int bin_avg(input int sel, input int bx, input int by);
    int s;
    int bs;
    int q;
    s  = 0;
    bs = geo_bw(sel) * geo_bh(sel);
    for (int y = by * geo_bh(sel); y < imin((by + 1) * geo_bh(sel), geo_h(sel)); y++)
      for (int x = bx * geo_bw(sel); x < imin((bx + 1) * geo_bw(sel), geo_w(sel)); x++)
        s += int'(img[sel][y][x]);
`ifdef GRAYSCALE_DOWNSAMPLER_ROUND_EN
    q = (s + bs / 2) / bs;
    if (q > 255) q = 255;
`else
    q = s / bs;
`endif
    return q;
  endfunction

  task automatic check_port(input int sel, input logic vld, input logic [7:0] dat);
    exp_t  e;
    bit    due;
    string nm;
    nm = (sel == 0) ? "a" : "b";
    if (sel == 0) due = (exp_a.size() > 0) && (exp_a[0].cyc == cyc);
    else          due = (exp_b.size() > 0) && (exp_b[0].cyc == cyc);
    if (due) begin
      if (sel == 0) e = exp_a.pop_front();
      else          e = exp_b.pop_front();
      check_eq($sformatf("%s_out_vld", nm), vld, 1);
      check_eq($sformatf("%s_out_dat", nm), dat, e.val);
    end else if (vld) begin
      check_eq($sformatf("%s_unexpected_vld", nm), vld, 0);
    end
    if (vld) begin
      if (out_cnt[sel] == 0) first_dat[sel] = int'(dat);
      out_cnt[sel]++;
    end
  endtask

  // Every bench wait goes through here: one negedge, one cycle count, one output check.
  task automatic tick();
    @(negedge clock);
    cyc++;
    if (reset) begin
      check_port(0, a_out_vld, a_out_dat);
      check_port(1, b_out_vld, b_out_dat);
    end
  endtask

  task automatic set_idle(input int sel);
    if (sel == 0) begin a_in_vld = 1'b0; a_in_dat = 8'($urandom); end
    else          begin b_in_vld = 1'b0; b_in_dat = 8'($urandom); end
  endtask

  // Drive one pixel (caller sits just after a negedge) and predict any bin it completes.
  task automatic put_px(input int sel, input logic [7:0] pix);
    int   x, y, bx, by;
    exp_t e;
    x = px_x[sel];
    y = px_y[sel];
    img[sel][y][x] = pix;
    if (sel == 0) begin a_in_vld = 1'b1; a_in_dat = pix; end
    else          begin b_in_vld = 1'b1; b_in_dat = pix; end
    bx = x / geo_bw(sel);
    by = y / geo_bh(sel);
    if (x == imin((bx + 1) * geo_bw(sel), geo_w(sel)) - 1 &&
        y == imin((by + 1) * geo_bh(sel), geo_h(sel)) - 1) begin
      e.val = bin_avg(sel, bx, by);
      e.cyc = cyc + 3;
      if (sel == 0) exp_a.push_back(e);
      else          exp_b.push_back(e);
    end
    x++;
    if (x == geo_w(sel)) begin
      x = 0;
      y++;
      if (y == geo_h(sel)) y = 0;
    end
    px_x[sel] = x;
    px_y[sel] = y;
  endtask

  // mode 0: constant level; 1: noisy around level; 2: bin-0 ramp 0..31, random elsewhere.
  task automatic run_px(input int sel, input int npix, input int mode, input int level, input bit sparse);
    logic [7:0] p;
    for (int i = 0; i < npix; i++) begin
      tick();
      if (sparse) begin
        while ($urandom_range(0, 2) != 0) begin
          set_idle(sel);
          tick();
        end
      end
      case (mode)
        0: p = 8'(level);
        1: p = 8'(level + int'($urandom_range(0, 16)) + int'($urandom_range(0, 16))
                        + int'($urandom_range(0, 16)) + int'($urandom_range(0, 16)) - 32);
        default: p = (px_x[sel] < A_BW && px_y[sel] < A_BH) ? 8'(px_y[sel] * A_BW + px_x[sel])
                                                           : 8'($urandom_range(0, 255));
      endcase
      put_px(sel, p);
    end
    tick();
    set_idle(sel);
  endtask

  task automatic do_reset(input int hold);
    tick();
    #1;
    reset    = 1'b0;
    a_in_vld = 1'b0;
    b_in_vld = 1'b0;
    exp_a.delete();
    exp_b.delete();
    for (int s = 0; s < 2; s++) begin
      px_x[s]      = 0;
      px_y[s]      = 0;
      out_cnt[s]   = 0;
      first_dat[s] = -1;
    end
    #1;
    check_eq("rst_a_vld", a_out_vld, 0);
    check_eq("rst_a_dat", a_out_dat, 0);
    check_eq("rst_b_vld", b_out_vld, 0);
    check_eq("rst_b_dat", b_out_dat, 0);
    repeat (hold) tick();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int ramp_exp;
`ifdef GRAYSCALE_DOWNSAMPLER_ROUND_EN
    ramp_exp = 16;
`else
    ramp_exp = 15;
`endif
    #1 reset = 1'b0;
    do_reset(2);

    // Idle after reset: no strobes, output still zero.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("idle_a_vld", a_out_vld, 0);
      check_eq("idle_a_dat", a_out_dat, 0);
      check_eq("idle_b_vld", b_out_vld, 0);
    end

    // Constant 8'h80 frame, continuous valid.
    run_px(0, A_W * A_H, 0, 8'h80, 1'b0);
    repeat (6) tick();
    check_eq("const_cnt", out_cnt[0], bins_per_frame(0));

    // Ten noisy frames back to back at 1/3 duty.
    for (int f = 0; f < 10; f++) begin
      run_px(0, A_W * A_H, 1, int'($urandom_range(64, 192)), 1'b1);
    end
    repeat (6) tick();
    check_eq("rand_cnt", out_cnt[0], 11 * bins_per_frame(0));

    // Bin 0 ramp 0..31 after a fresh reset.
    do_reset(2);
    run_px(0, A_W * A_H, 2, 0, 1'b0);
    repeat (6) tick();
    check_eq("bin0_ramp", first_dat[0], ramp_exp);
    check_eq("ramp_cnt", out_cnt[0], bins_per_frame(0));

    // 6x12 bins full of 8'hFF: largest sums, must not overflow.
    run_px(1, B_W * B_H, 0, 8'hFF, 1'b0);
    repeat (6) tick();
    check_eq("b_cnt", out_cnt[1], bins_per_frame(1));
    check_eq("b_first", first_dat[1], 255);

    // Reset mid-frame, then a clean constant 8'h40 frame.
    run_px(0, 300, 1, 128, 1'b0);
    do_reset(2);
    run_px(0, A_W * A_H, 0, 8'h40, 1'b0);
    repeat (6) tick();
    check_eq("post_rst_cnt", out_cnt[0], bins_per_frame(0));
    check_eq("post_rst_first", first_dat[0], 8'h40);

    check_eq("a_pending", exp_a.size(), 0);
    check_eq("b_pending", exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
